// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter in front of the unified byte-addressed
// instruction/data memory. Fetch and load/store requests share the one
// memory port; each granted access takes one memory cycle and completes with
// a one-cycle ready pulse carrying registered read data.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   if_req/if_addr    fetch request (held until if_ready)
//   if_ready/if_instr fetch completion pulse and registered word
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata  load/store request
//   d_ready/d_rdata/d_fault  data completion pulse, result, misalign flag
//   mem_*             memory port controls; mem_rdata is combinational
//   stall             pipeline stall while any request is outstanding
//
// Parameter DATA_PRIO: 1 = data wins simultaneous requests, 0 = fetch wins.
// Macro ARB_MISALIGN_TRAP_EN: when defined, misaligned half/word data
// requests complete with d_fault instead of issuing a memory cycle.
module mem_arbiter #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ready,
    output logic [31:0] if_instr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_by,
    output logic        mem_half,
    output logic        mem_unsign,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, FAULT} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [7:0]  daddr_q, daddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  iaddr_q, iaddr_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_fault_q, d_fault_d;

    logic d_elig, f_elig, misalign;

    // A requester whose ready pulse is high is still holding its (already
    // served) request this cycle, so it must not be granted again.
    assign d_elig = d_req & ~d_ready_q;
    assign f_elig = if_req & ~if_ready_q;

`ifdef ARB_MISALIGN_TRAP_EN
    assign misalign = ((d_size == 2'b01) && d_addr[0]) ||
                      (d_size[1] && (d_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        daddr_d    = daddr_q;
        wdata_d    = wdata_q;
        iaddr_d    = iaddr_q;
        if_ready_d = 1'b0;
        if_instr_d = if_instr_q;
        d_ready_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_fault_d  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_by     = 1'b0;
        mem_half   = 1'b0;
        mem_unsign = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 32'h0;

        case (state_q)
            IDLE: begin
                if (d_elig && (DATA_PRIO || !f_elig)) begin
                    we_d    = d_we;
                    size_d  = d_size;
                    uns_d   = d_unsigned;
                    daddr_d = d_addr;
                    wdata_d = d_wdata;
                    state_d = misalign ? FAULT : DATA;
                end else if (f_elig) begin
                    iaddr_d = if_addr;
                    state_d = FETCH;
                end
            end
            DATA: begin
                mem_read   = ~we_q;
                mem_write  = we_q;
                mem_by     = (size_q == 2'b00);
                mem_half   = (size_q == 2'b01);
                mem_unsign = uns_q;
                mem_addr   = daddr_q;
                mem_wdata  = wdata_q;
                d_rdata_d  = we_q ? 32'h0 : mem_rdata;
                d_ready_d  = 1'b1;
                state_d    = IDLE;
            end
            FETCH: begin
                mem_read   = 1'b1;
                mem_addr   = iaddr_q;
                if_instr_d = mem_rdata;
                if_ready_d = 1'b1;
                state_d    = IDLE;
            end
            FAULT: begin
                d_ready_d = 1'b1;
`ifdef ARB_MISALIGN_TRAP_EN
                d_fault_d = 1'b1;
`endif
                d_rdata_d = 32'h0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            daddr_q    <= 8'h00;
            wdata_q    <= 32'h0;
            iaddr_q    <= 8'h00;
            if_ready_q <= 1'b0;
            if_instr_q <= 32'h0;
            d_ready_q  <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_fault_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            daddr_q    <= daddr_d;
            wdata_q    <= wdata_d;
            iaddr_q    <= iaddr_d;
            if_ready_q <= if_ready_d;
            if_instr_q <= if_instr_d;
            d_ready_q  <= d_ready_d;
            d_rdata_q  <= d_rdata_d;
            d_fault_q  <= d_fault_d;
        end
    end

    assign if_ready = if_ready_q;
    assign if_instr = if_instr_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;
    assign d_fault  = d_fault_q;
    assign stall    = (d_req & ~d_ready_q) | (if_req & ~if_ready_q);

endmodule
